// File: rtl/wavepool_instr_sender_pkg.sv
// rtl/wavepool_instr_sender_pkg.sv - shared sizes and FSM encoding for the wavepool instruction sender
package wavepool_instr_sender_pkg;

    localparam int NUM_WF_DEF = 40;
    localparam int QDEPTH_DEF = 4;
    localparam int WFID_W     = 6;
    localparam int VGPR_W     = 10;
    localparam int SGPR_W     = 9;
    localparam int LDS_W      = 16;

    typedef enum logic [1:0] {
        ST_SELECT = 2'd0,
        ST_CHECK  = 2'd1,
        ST_HALF   = 2'd2
    } state_t;

endpackage

// File: rtl/wavepool_instr_sender_wf_rr_arbiter.sv
// rtl/wavepool_instr_sender_wf_rr_arbiter.sv - combinational round-robin pick of the first eligible wavefront at or after rr_ptr
module wf_rr_arbiter
    import wavepool_instr_sender_pkg::*;
#(
    parameter int NUM_WF = NUM_WF_DEF
) (
    input  logic [NUM_WF-1:0] i_eligible,
    input  logic [WFID_W-1:0] i_rr_ptr,
    output logic [NUM_WF-1:0] o_grant,
    output logic [WFID_W-1:0] o_grant_wfid,
    output logic              o_any_grant
);

    logic [WFID_W:0]   w_sum;
    logic [WFID_W-1:0] w_idx;

    always_comb begin
        o_grant      = '0;
        o_grant_wfid = '0;
        o_any_grant  = 1'b0;
        w_sum        = '0;
        w_idx        = '0;
        for (int off = 0; off < NUM_WF; off++) begin
            // One extra bit so rr_ptr + off cannot overflow before the explicit wrap.
            w_sum = {1'b0, i_rr_ptr} + (WFID_W + 1)'(off);
            if (w_sum >= (WFID_W + 1)'(NUM_WF)) begin
                w_sum = w_sum - (WFID_W + 1)'(NUM_WF);
            end
            w_idx = w_sum[WFID_W-1:0];
            if (!o_any_grant && i_eligible[w_idx]) begin
                o_any_grant    = 1'b1;
                o_grant[w_idx] = 1'b1;
                o_grant_wfid   = w_idx;
            end
        end
    end

endmodule

// File: rtl/wavepool_instr_sender.sv
// rtl/wavepool_instr_sender.sv - per-wavefront dword queues, round-robin send and half-instruction follow-up; WAVEPOOL_SENDER_PROTO_CHECK_EN enables protocol_err
module wavepool_instr_sender
    import wavepool_instr_sender_pkg::*;
#(
    parameter int NUM_WF = NUM_WF_DEF,
    parameter int QDEPTH = QDEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_wr_en,
    input  logic [WFID_W-1:0] fetch_wfid,
    input  logic [31:0]       fetch_instr,
    input  logic [31:0]       fetch_pc,
    output logic [NUM_WF-1:0] wf_q_full,
    input  logic              new_wf_valid,
    input  logic [WFID_W-1:0] new_wfid,
    input  logic [VGPR_W-1:0] new_vgpr_base,
    input  logic [SGPR_W-1:0] new_sgpr_base,
    input  logic [LDS_W-1:0]  new_lds_base,
    input  logic [NUM_WF-1:0] issue_ready,
    input  logic              flush_valid,
    input  logic [WFID_W-1:0] flush_wfid,
    output logic              wave_instr_valid,
    output logic [31:0]       wave_instr,
    output logic [31:0]       wave_instr_pc,
    output logic [WFID_W-1:0] wave_wfid,
    output logic [VGPR_W-1:0] wave_vgpr_base,
    output logic [SGPR_W-1:0] wave_sgpr_base,
    output logic [LDS_W-1:0]  wave_lds_base,
    input  logic              wave_ins_half_rqd,
    input  logic [WFID_W-1:0] wave_ins_half_wfid,
    output logic              protocol_err
);

    localparam int PTR_W = $clog2(QDEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [31:0]       r_q_instr [NUM_WF][QDEPTH];
    logic [31:0]       r_q_pc    [NUM_WF][QDEPTH];
    logic [PTR_W-1:0]  r_wr_ptr  [NUM_WF];
    logic [PTR_W-1:0]  r_rd_ptr  [NUM_WF];
    logic [CNT_W-1:0]  r_count   [NUM_WF];
    logic [VGPR_W-1:0] r_vgpr_tbl [NUM_WF];
    logic [SGPR_W-1:0] r_sgpr_tbl [NUM_WF];
    logic [LDS_W-1:0]  r_lds_tbl  [NUM_WF];

    state_t            r_state;
    logic [WFID_W-1:0] r_lock_wfid;
    logic [WFID_W-1:0] r_rr_ptr;

    logic [NUM_WF-1:0] w_nonempty;
    logic [NUM_WF-1:0] w_flush_mask;
    logic [NUM_WF-1:0] w_wr_mask;
    logic [NUM_WF-1:0] w_eligible;
    logic [NUM_WF-1:0] w_grant;
    logic [NUM_WF-1:0] w_pop_mask;
    logic [WFID_W-1:0] w_grant_wfid;
    logic [WFID_W-1:0] w_pop_wfid;
    logic              w_any_grant;
    logic              w_pop;
    logic              w_lock_flushed;

    always_comb begin
        w_nonempty   = '0;
        wf_q_full    = '0;
        w_flush_mask = '0;
        w_wr_mask    = '0;
        for (int w = 0; w < NUM_WF; w++) begin
            w_nonempty[w]   = (r_count[w] != '0);
            wf_q_full[w]    = (r_count[w] == CNT_W'(QDEPTH));
            w_flush_mask[w] = flush_valid && (flush_wfid == WFID_W'(w));
            // Flush beats a same-cycle write; full queues drop the write.
            w_wr_mask[w]    = fetch_wr_en && (fetch_wfid == WFID_W'(w))
                              && !wf_q_full[w] && !w_flush_mask[w];
        end
        w_eligible     = issue_ready & w_nonempty & ~w_flush_mask;
        w_lock_flushed = flush_valid && (flush_wfid == r_lock_wfid);
    end

    wf_rr_arbiter #(
        .NUM_WF(NUM_WF)
    ) u_arb (
        .i_eligible  (w_eligible),
        .i_rr_ptr    (r_rr_ptr),
        .o_grant     (w_grant),
        .o_grant_wfid(w_grant_wfid),
        .o_any_grant (w_any_grant)
    );

    always_comb begin
        w_pop      = 1'b0;
        w_pop_wfid = r_lock_wfid;
        w_pop_mask = '0;
        case (r_state)
            ST_SELECT: begin
                if (w_any_grant) begin
                    w_pop      = 1'b1;
                    w_pop_wfid = w_grant_wfid;
                    w_pop_mask = w_grant;
                end
            end
            ST_HALF: begin
                if (!w_lock_flushed && w_nonempty[r_lock_wfid]) begin
                    w_pop                   = 1'b1;
                    w_pop_mask[r_lock_wfid] = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int w = 0; w < NUM_WF; w++) begin
                r_wr_ptr[w] <= '0;
                r_rd_ptr[w] <= '0;
                r_count[w]  <= '0;
            end
        end else begin
            for (int w = 0; w < NUM_WF; w++) begin
                if (w_flush_mask[w]) begin
                    r_wr_ptr[w] <= '0;
                    r_rd_ptr[w] <= '0;
                    r_count[w]  <= '0;
                end else begin
                    if (w_wr_mask[w]) r_wr_ptr[w] <= r_wr_ptr[w] + 1'b1;
                    if (w_pop_mask[w]) r_rd_ptr[w] <= r_rd_ptr[w] + 1'b1;
                    r_count[w] <= r_count[w] + CNT_W'(w_wr_mask[w]) - CNT_W'(w_pop_mask[w]);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int w = 0; w < NUM_WF; w++) begin
            if (w_wr_mask[w]) begin
                r_q_instr[w][r_wr_ptr[w]] <= fetch_instr;
                r_q_pc[w][r_wr_ptr[w]]    <= fetch_pc;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int w = 0; w < NUM_WF; w++) begin
                r_vgpr_tbl[w] <= '0;
                r_sgpr_tbl[w] <= '0;
                r_lds_tbl[w]  <= '0;
            end
        end else begin
            for (int w = 0; w < NUM_WF; w++) begin
                if (new_wf_valid && (new_wfid == WFID_W'(w))) begin
                    r_vgpr_tbl[w] <= new_vgpr_base;
                    r_sgpr_tbl[w] <= new_sgpr_base;
                    r_lds_tbl[w]  <= new_lds_base;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state          <= ST_SELECT;
            r_lock_wfid      <= '0;
            r_rr_ptr         <= '0;
            wave_instr_valid <= 1'b0;
            wave_instr       <= '0;
            wave_instr_pc    <= '0;
            wave_wfid        <= '0;
            wave_vgpr_base   <= '0;
            wave_sgpr_base   <= '0;
            wave_lds_base    <= '0;
        end else begin
            wave_instr_valid <= w_pop;
            if (w_pop) begin
                wave_instr     <= r_q_instr[w_pop_wfid][r_rd_ptr[w_pop_wfid]];
                wave_instr_pc  <= r_q_pc[w_pop_wfid][r_rd_ptr[w_pop_wfid]];
                wave_wfid      <= w_pop_wfid;
                wave_vgpr_base <= r_vgpr_tbl[w_pop_wfid];
                wave_sgpr_base <= r_sgpr_tbl[w_pop_wfid];
                wave_lds_base  <= r_lds_tbl[w_pop_wfid];
            end
            case (r_state)
                ST_SELECT: begin
                    if (w_any_grant) begin
                        r_lock_wfid <= w_grant_wfid;
                        r_rr_ptr    <= (w_grant_wfid == WFID_W'(NUM_WF - 1)) ? '0
                                                                              : w_grant_wfid + 1'b1;
                        r_state     <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    // Decode answers the dword currently held in its input flop.
                    if (!w_lock_flushed && wave_ins_half_rqd) r_state <= ST_HALF;
                    else r_state <= ST_SELECT;
                end
                ST_HALF: begin
                    if (w_lock_flushed || w_pop) r_state <= ST_SELECT;
                end
                default: r_state <= ST_SELECT;
            endcase
        end
    end

`ifdef WAVEPOOL_SENDER_PROTO_CHECK_EN
    logic r_proto_err;
    logic w_fetch_full;

    always_comb begin
        w_fetch_full = 1'b0;
        for (int w = 0; w < NUM_WF; w++) begin
            if (fetch_wr_en && (fetch_wfid == WFID_W'(w)) && wf_q_full[w]) w_fetch_full = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_proto_err <= 1'b0;
        end else if ((wave_ins_half_rqd && (r_state != ST_CHECK))
                  || (wave_ins_half_rqd && (r_state == ST_CHECK) && (wave_ins_half_wfid != r_lock_wfid))
                  || w_fetch_full) begin
            r_proto_err <= 1'b1;
        end
    end

    assign protocol_err = r_proto_err;
`else
    logic w_unused_half_wfid;
    assign w_unused_half_wfid = ^wave_ins_half_wfid;
    assign protocol_err       = 1'b0;
`endif

endmodule

// File: doc/wavepool_instr_sender.md
Name: wavepool_instr_sender

Overview:
- Producer side of the wavepool→decode interface.
- Buffers fetched instruction dwords per wavefront and picks a ready wavefront round-robin.
- Drives one dword per send on wave_instr/wave_instr_pc/wave_wfid together with that wavefront's register and LDS bases.
- Answers decode's wave_ins_half_rqd by sending the same wavefront's next dword (second half of a 64-bit instruction or literal) on the next slot.

Parameters:
- NUM_WF, 40, number of wavefront slots; wfid is 6 bits.
- QDEPTH, 4, dword entries per wavefront queue; power of two, ≥2.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- fetch_wr_en  in  1  write one fetched dword
- fetch_wfid  in  6  target wavefront for the write
- fetch_instr  in  32  instruction dword
- fetch_pc  in  32  PC of the dword
- wf_q_full  out  NUM_WF  per-wavefront queue-full mask, combinational from the counts
- new_wf_valid  in  1  register bases for a new wavefront
- new_wfid  in  6  wavefront being registered
- new_vgpr_base  in  10  VGPR base
- new_sgpr_base  in  9  SGPR base
- new_lds_base  in  16  LDS base
- issue_ready  in  NUM_WF  wavefront may send
- flush_valid  in  1  flush one wavefront queue
- flush_wfid  in  6  wavefront to flush
- wave_instr_valid  out  1  dword valid this cycle
- wave_instr  out  32  dword
- wave_instr_pc  out  32  PC of the dword
- wave_wfid  out  6  owning wavefront
- wave_vgpr_base  out  10  VGPR base of wave_wfid
- wave_sgpr_base  out  9  SGPR base of wave_wfid
- wave_lds_base  out  16  LDS base of wave_wfid
- wave_ins_half_rqd  in  1  decode needs the second dword
- wave_ins_half_wfid  in  6  wavefront of that request
- protocol_err  out  1  sticky protocol-violation flag

Behaviour:
- Reset (async, rst=1):
  - all queue counts and pointers 0; round-robin pointer 0; state SELECT.
  - all wave_* outputs 0; protocol_err 0.
  - base table cleared to 0.
- wave_* outputs are registered. A dword popped in cycle t is visible in cycle t+1. wave_instr_valid pulses exactly one cycle per dword.
- Queues:
  - Per-wavefront circular buffer of {pc, instr}, depth QDEPTH, with a (log2 QDEPTH + 1)-bit count.
  - Write to a full queue is dropped.
  - Write and pop on the same wavefront in the same cycle: both occur and the count is unchanged. Pointers wrap modulo QDEPTH.
- Base table: new_valid writes {vgpr, sgpr, lds}[new_wfid]. Base outputs are read from the table in the same cycle as the dword pop.
- Flush:
  - Clears the count and pointers of flush_wfid in one cycle.
  - A write to the same wavefront in the same cycle is dropped; flush wins.
  - The flushed wavefront is excluded from that cycle's selection.
- FSM states:
  - SELECT:
    - Eligible = issue_ready & non-empty & not flushed this cycle.
    - Grant the first eligible wavefront at or after rr_ptr (wrapping); pop its head; latch lock_wfid = grant; rr_ptr ← (grant+1) mod NUM_WF.
    - Go to CHECK.
    - If nothing is eligible, stay in SELECT with valid 0.
  - CHECK: mandatory bubble, no pop, valid 0 in the following cycle. Sample wave_ins_half_rqd, which is decode's response to the dword now in its input flop.
    - rqd=1 → HALF.
    - rqd=0 → SELECT.
  - HALF: send lock_wfid's head regardless of issue_ready, then go to SELECT.
    - If the queue is empty, stall in HALF and send nothing from any wavefront.
    - A flush of lock_wfid while in CHECK or HALF → SELECT with no send.
- Throughput: at most one new instruction every 2 cycles; a 64-bit instruction takes 3 cycles (SELECT, CHECK, HALF).
- NUM_WF not a power of two: rr_ptr increment wraps explicitly at NUM_WF-1 → 0.

Optional Feature:
- Macro WAVEPOOL_SENDER_PROTO_CHECK_EN.
- Defined: protocol_err sets and holds until reset on any of:
  - wave_ins_half_rqd asserted outside CHECK;
  - wave_ins_half_wfid ≠ lock_wfid in CHECK;
  - fetch_wr_en to a full queue.
- Undefined: protocol_err tied 0; the checking logic is absent.

Decomposition:
- Shared package: NUM_WF and QDEPTH defaults, WFID_W=6, base widths 10/9/16, the FSM state encoding {SELECT, CHECK, HALF}.
- One sub-module, wf_rr_arbiter: eligible mask plus rr_ptr in; one-hot grant, encoded wfid and any-grant out; purely combinational.

Test Plan:
- Single 32-bit instr: base table for wf 3 = vgpr 0x040 / sgpr 0x020 / lds 0x0100; write 0xBF810000 @ pc 0x100 to wf 3, issue_ready[3]=1 → one valid pulse carrying 0xBF810000 / pc 0x100 / wfid 3 / bases 0x040, 0x020, 0x0100; next dword no earlier than 2 cycles later.
- Literal: wf 5 holds 0x7E0002FF, 0x3F800000; drive half_rqd with wfid 5 in CHECK → 0x3F800000 sent in the third cycle, wfid 5, then SELECT.
- Half stall: wf 5 half requested with an empty queue; wf 6 ready and non-empty → no send for 4 cycles; write wf 5 → its dword sent the cycle after the write; wf 6 sent afterwards.
- Round-robin: wf 0, 1, 2 each hold 2 dwords, all ready, no half requests → send order 0, 1, 2, 0, 1, 2.
- Full/flush: 5 writes to wf 7 (QDEPTH 4) → wf_q_full[7]=1 and the 5th write is dropped (protocol_err=1 with the macro); flush wf 7 together with a write → count 0, nothing sent.
- Mid-operation reset: assert rst while in HALF → outputs 0 immediately; after release, state SELECT with all queues empty.
